// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder: operation encodings and operand-prep helpers.
package adder_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_ADC = 2'b10;
    localparam op_t OP_SBB = 2'b11;

    // Subtracts are done as a + ~b + c0, so only the B operand is inverted.
    function automatic logic op_inverts_b(op_t op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // SBB is a - b - !cin, which becomes a + ~b + cin.
    function automatic logic op_carry_in(op_t op, logic cin);
        logic c;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_SUB:  c = 1'b1;
            default: c = cin;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CW-bit ripple adder; also reports the carry into its top bit for overflow.
module chunk_adder #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout,
    output logic          c_msb_in
);

    logic [CW:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CW; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[CW];
    assign c_msb_in = c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ADD/SUB/ADC/SBB: one CW-bit chunk summed per stage, carry rippling stage to stage.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CW = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    // Handshake: a beat moves on any edge where valid && ready. The whole pipe advances
    // together (adv); while the output is valid and not taken, every stage holds and
    // in_ready is low, so the source must keep presenting its beat.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_eff;
    logic             c0;
    assign b_eff = op_inverts_b(op) ? ~b : b;
    assign c0    = op_carry_in(op, cin);

    // Element k of the *_r arrays is the register at the output of stage k.
    // x_r holds finished sum chunks below chunk k+1 and still-unused A chunks above.
    logic [WIDTH-1:0] x_r [STAGES];
    logic [WIDTH-1:0] b_r [STAGES];
    logic             c_r [STAGES];
    logic             z_r [STAGES];
    logic             o_r [STAGES];
    logic             v_r [STAGES];

    // Stage inputs: ports for stage 0, previous stage registers otherwise.
    logic [WIDTH-1:0] sx [STAGES];
    logic [WIDTH-1:0] sb [STAGES];
    logic             sc [STAGES];
    logic             sz [STAGES];
    logic             sv [STAGES];

    logic [CW-1:0]    s_c  [STAGES];
    logic             co_c [STAGES];
    logic             cm_c [STAGES];

    function automatic logic [WIDTH-1:0] splice(logic [WIDTH-1:0] w, logic [CW-1:0] chunk, int k);
        logic [WIDTH-1:0] r;
        r = w;
        r[k*CW +: CW] = chunk;
        return r;
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign sx[k] = a;
            assign sb[k] = b_eff;
            assign sc[k] = c0;
            assign sz[k] = 1'b1;
            assign sv[k] = in_valid;
        end else begin : g_tail
            assign sx[k] = x_r[k-1];
            assign sb[k] = b_r[k-1];
            assign sc[k] = c_r[k-1];
            assign sz[k] = z_r[k-1];
            assign sv[k] = v_r[k-1];
        end

        chunk_adder #(.CW(CW)) u_chunk (
            .a        (sx[k][k*CW +: CW]),
            .b        (sb[k][k*CW +: CW]),
            .cin      (sc[k]),
            .s        (s_c[k]),
            .cout     (co_c[k]),
            .c_msb_in (cm_c[k])
        );

        // o_r is only meaningful in the last stage, where the chunk top bit is the word MSB.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r[k] <= 1'b0;
                x_r[k] <= '0;
                b_r[k] <= '0;
                c_r[k] <= 1'b0;
                z_r[k] <= 1'b0;
                o_r[k] <= 1'b0;
            end else if (adv) begin
                v_r[k] <= sv[k];
                x_r[k] <= splice(sx[k], s_c[k], k);
                b_r[k] <= sb[k];
                c_r[k] <= co_c[k];
                z_r[k] <= sz[k] && (s_c[k] == '0);
                o_r[k] <= cm_c[k] ^ co_c[k];
            end
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign sum       = x_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign ovf       = o_r[STAGES-1];
    assign zero      = z_r[STAGES-1];
    assign neg       = x_r[STAGES-1][WIDTH-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised scoreboard bench for pipelined_adder with an arithmetic reference model.
module tb_pipelined_adder;

    localparam int W  = 32;
    localparam int S  = 4;
    localparam int RW = W + 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout, ovf, zero, neg;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [RW-1:0] exp_q[$];
    int            lat_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            adv_cnt = 0;
    int            rmode = 0;
    int            bcyc = 0;
    logic          prev_hold = 1'b0;
    logic [RW-1:0] held = '0;
    logic [RW-1:0] got = '0;

    task automatic check(string nm, logic [127:0] act, logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: exact wide integer arithmetic, then wrap and derive flags.
    function automatic logic [RW-1:0] model(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic ci);
        longint ux, uy, sxv, syv, ur, sr, smax, smin;
        logic [W-1:0] r;
        logic co, ov;
        ux   = longint'(x);
        uy   = longint'(y);
        sxv  = longint'($signed(x));
        syv  = longint'($signed(y));
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        case (o)
            2'b00:   begin ur = ux + uy;              sr = sxv + syv;              end
            2'b01:   begin ur = ux - uy;              sr = sxv - syv;              end
            2'b10:   begin ur = ux + uy + (ci ? 1 : 0); sr = sxv + syv + (ci ? 1 : 0); end
            default: begin ur = ux - uy - (ci ? 0 : 1); sr = sxv - syv - (ci ? 0 : 1); end
        endcase
        if (o == 2'b00 || o == 2'b10) co = (ur >= (longint'(1) << W));
        else                          co = (ur >= 0);
        ov = (sr > smax) || (sr < smin);
        r  = ur[W-1:0];
        return {r, co, ov, (r == '0), r[W-1]};
    endfunction

    function automatic logic [W-1:0] rand_val();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            4:       v = W'($urandom_range(0, 3));
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // driver tasks
    task automatic drive_ready();
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(bcyc >= 5 && bcyc <= 7);
        endcase
        bcyc++;
    endtask

    task automatic send(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y, logic ci, logic [RW-1:0] e);
        int tries;
        tries = 0;
        forever begin
            @(negedge clk);
            drive_ready();
            in_valid = 1'b1;
            op  = o;
            a   = x;
            b   = y;
            cin = ci;
            #1;
            if (in_ready) begin
                exp_q.push_back(e);
                lat_q.push_back(adv_cnt);
                break;
            end
            tries++;
            if (tries > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", tries);
                break;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        drive_ready();
        in_valid = 1'b0;
        op  = 2'($urandom_range(0, 3));
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        rmode = 0;
        while (exp_q.size() != 0 && t < 100) begin
            idle();
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_flags"}, {cout, ovf, zero, neg}, 4'b0000);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic send_rand();
        logic [1:0]   o;
        logic [W-1:0] x, y;
        logic         ci;
        o  = 2'($urandom_range(0, 3));
        x  = rand_val();
        y  = rand_val();
        ci = 1'($urandom_range(0, 1));
        send(o, x, y, ci, model(o, x, y, ci));
    endtask

    // monitor: pops and compares whenever a beat is taken at the output
    initial begin
        forever begin
            @(negedge clk);
            #2;
            got = {sum, cout, ovf, zero, neg};
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                check("in_ready", in_ready, !(out_valid && !out_ready));
                if (out_valid) begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        if (prev_hold) check("hold_stable", got, held);
                        else           check("latency", adv_cnt - lat_q[0], S);
                        if (out_ready) begin
                            check("result", got, exp_q[0]);
                            void'(exp_q.pop_front());
                            void'(lat_q.pop_front());
                        end
                    end
                    prev_hold = !out_ready;
                    held      = got;
                end else begin
                    prev_hold = 1'b0;
                end
                if (!(out_valid && !out_ready)) adv_cnt++;
            end
        end
    end

    // stimulus
    initial begin
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        rmode = 0;
        send(2'b00, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, {32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0});
        send(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0});
        send(2'b10, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1});
        send(2'b11, 32'h0000_0005, 32'h0000_0005, 1'b0, {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1});
        drain();

        rmode = 2;
        bcyc  = 0;
        for (int i = 0; i < 8; i++) send(2'b00, W'(i), W'(i), 1'b0, model(2'b00, W'(i), W'(i), 1'b0));
        drain();

        rmode = 0;
        for (int i = 0; i < 6; i++) send(2'b00, W'(100 + i), W'(1), 1'b0, model(2'b00, W'(100 + i), W'(1), 1'b0));
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("reset_in_flight");
        exp_q.delete();
        lat_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) idle();
        send(2'b01, 32'd50, 32'd8, 1'b0, model(2'b01, 32'd50, 32'd8, 1'b0));
        drain();

        rmode = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            else                           send_rand();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
